truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Self-checking stimulus sequencer that sits directly upstream of the 4-input/2-output combinational logic block. It drives the block's `a`, `b`, `c`, `d` inputs through all 16 combinations in ascending order, holds each combination for a programmable number of cycles, and samples the block's `y` and `z` outputs. It compares each sample against parameterised expected truth tables and reports pass/fail, the mismatch count and the first failing vector. It replaces hand-written exhaustive stimulus with a reusable, synthesizable on-chip checker.

## Interface
Parameters:
- `HOLD`, 2: cycles each input vector is held; legal range 1–255. 0 is illegal.
- `EXP_Y`, 16'h8000: expected `y`; bit i is the value for vector i, where i = {a,b,c,d} and `a` is the MSB.
- `EXP_Z`, 16'hFFFE: expected `z`, same bit ordering as `EXP_Y`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep.
- `a`, `b`, `c`, `d`  out  1 each  registered drive to the downstream block.
- `y`, `z`  in  1 each  downstream block outputs.
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  high from sweep completion until the next start or reset.
- `pass`  out  1  valid while `done` is high; 1 when `err_cnt` is 0.
- `err_cnt`  out  5  number of mismatching vectors, 0–16.
- `first_err`  out  4  index of the first mismatching vector.
- `first_err_valid`  out  1  high when `first_err` holds a captured index.

## Operation
States:
- IDLE: `busy`=0. `start`=1 goes to DRIVE.
- DRIVE: `busy`=1. Moves to DONE after vector 15 is compared.
- DONE: `done`=1. `start`=1 goes to DRIVE.
- Any state: `rst` goes to IDLE.

Entering DRIVE from IDLE or DONE:
- `vec` and `hcnt` are cleared to 0.
- `err_cnt`, `first_err` and `first_err_valid` are cleared.
- `done` and `pass` are cleared.

In DRIVE:
- {a,b,c,d} = `vec`, registered.
- `hcnt` counts 0..HOLD-1.
- In the cycle where `hcnt` == HOLD-1, the block compares y against EXP_Y[vec] and z against EXP_Z[vec]. A vector mismatches if either output differs.
- On a mismatch, `err_cnt` increments. If `first_err_valid` is 0, the block captures `first_err`=`vec` and sets `first_err_valid`=1.
- On the same edge, if `vec` < 15, then `vec` increments and `hcnt` returns to 0. If `vec` == 15, the state moves to DONE.
- A mismatch on vector 15 is counted on the same edge that enters DONE, so `err_cnt` is final when `done` rises.

In DONE:
- `pass` = (`err_cnt` == 0).
- `a`..`d` hold 4'b1111.
- `err_cnt`, `first_err`, `first_err_valid` and `pass` remain stable until the next `start` or `rst`.

Other rules:
- `start` while `busy` is ignored; the sweep continues unchanged.
- `err_cnt` is 5 bits wide, so the maximum of 16 needs no saturation.

## Timing
- Reset values: state IDLE; `a`=`b`=`c`=`d`=0; `busy`=0, `done`=0, `pass`=0; `err_cnt`=0, `first_err`=0, `first_err_valid`=0.
- Reset mid-sweep takes effect on that edge and applies the reset values above. Nothing from the aborted sweep is kept.
- Let edge E0 be the edge at which `start` is sampled. After E0: `busy`=1 and vector 0 is on `a`..`d`.
- Vector n is driven from edge E0+n·HOLD and compared in the cycle before edge E0+(n+1)·HOLD.
- `done` rises, and `busy` falls, after edge E0+16·HOLD. Sweep latency is exactly 16·HOLD cycles.
- With HOLD=1, the block samples in the same cycle the vector is presented. It relies on the downstream block being purely combinational.
- `start` and `rst` high together: reset wins.

## Test plan
- Reset: hold `rst` for 2 cycles with `start`=1 → all outputs at their reset values, state IDLE.
- Golden model (y=a&b&c&d, z=a|b|c|d), HOLD=2: pulse `start` → `a`..`d` step 0..15, each held 2 cycles; `done` rises 32 cycles after the start edge; `err_cnt`=0, `pass`=1, `first_err_valid`=0.
- Inject fault `y` stuck at 0 → `err_cnt`=1, `first_err`=15, `first_err_valid`=1, `pass`=0. Also inject `z` inverted → `err_cnt`=16, `first_err`=0.
- Pulse `start` at vector 5 → ignored, `done` at the original cycle. Assert `rst` during vector 7 → IDLE, `a`..`d`=0, `err_cnt`=0; a new `start` runs the full 16 vectors.
- Run with a fault, then `start` from DONE with the golden model → counters clear on the start edge, `pass`=1. With HOLD=1, `done` rises 16 cycles after the start edge.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Purpose : exhaustive on-chip stimulus/checker for a 4-in/2-out combinational block.
// Latency : 16*HOLD cycles from the start edge to done; a..d are registered outputs.
// Backpressure: none; start is accepted only in IDLE/DONE and ignored while busy.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   start               - one-cycle sweep request
//   a, b, c, d          - registered drive to the block under check ({a,b,c,d} = vector)
//   y, z                - block outputs, sampled on the last hold cycle of each vector
//   busy, done, pass    - sweep status; pass is meaningful while done is high
//   err_cnt             - number of mismatching vectors (0..16)
//   first_err(_valid)   - index of the first mismatching vector and its capture flag
//
// HOLD must lie in 1..255. With HOLD=1 the sample happens in the same cycle the
// vector is presented, which relies on the downstream block being purely combinational.
module truth_table_sweeper #(
    parameter int unsigned  HOLD  = 2,
    parameter logic [15:0]  EXP_Y = 16'h8000,
    parameter logic [15:0]  EXP_Z = 16'hFFFE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       y,
    input  logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic [3:0] first_err,
    output logic       first_err_valid
);

    // Terminal value of the hold counter; the compare happens while hcnt sits here.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t     state_q,   state_d;
    logic [3:0] vec_q,     vec_d;
    logic [7:0] hcnt_q,    hcnt_d;
    logic [3:0] abcd_q,    abcd_d;
    logic       busy_q,    busy_d;
    logic       done_q,    done_d;
    logic       pass_q,    pass_d;
    logic [4:0] err_cnt_q, err_cnt_d;
    logic [3:0] first_err_q, first_err_d;
    logic       first_err_valid_q, first_err_valid_d;

    logic       mismatch;
    logic       sample_now;

    // A vector fails if either output disagrees with its expected table bit.
    assign mismatch   = (y != EXP_Y[vec_q]) || (z != EXP_Z[vec_q]);
    assign sample_now = (hcnt_q == HOLD_LAST);

    always_comb begin
        state_d           = state_q;
        vec_d             = vec_q;
        hcnt_d            = hcnt_q;
        abcd_d            = abcd_q;
        busy_d            = busy_q;
        done_d            = done_q;
        pass_d            = pass_q;
        err_cnt_d         = err_cnt_q;
        first_err_d       = first_err_q;
        first_err_valid_d = first_err_valid_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Launching a sweep wipes every result of the previous one.
                if (start) begin
                    state_d           = ST_DRIVE;
                    vec_d             = 4'd0;
                    hcnt_d            = 8'd0;
                    abcd_d            = 4'd0;
                    busy_d            = 1'b1;
                    done_d            = 1'b0;
                    pass_d            = 1'b0;
                    err_cnt_d         = 5'd0;
                    first_err_d       = 4'd0;
                    first_err_valid_d = 1'b0;
                end
            end

            ST_DRIVE: begin
                if (sample_now) begin
                    if (mismatch) begin
                        // 5-bit counter holds the worst case of 16 without wrapping.
                        err_cnt_d = err_cnt_q + 5'd1;
                        if (!first_err_valid_q) begin
                            first_err_d       = vec_q;
                            first_err_valid_d = 1'b1;
                        end
                    end

                    if (vec_q != 4'hF) begin
                        vec_d  = vec_q + 4'd1;
                        hcnt_d = 8'd0;
                        abcd_d = vec_q + 4'd1;
                    end else begin
                        // Vector 15's verdict is folded in on this same edge, so
                        // err_cnt and pass are already final when done rises.
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        abcd_d  = 4'hF;
                        pass_d  = (err_cnt_d == 5'd0);
                    end
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            vec_q             <= 4'd0;
            hcnt_q            <= 8'd0;
            abcd_q            <= 4'd0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            err_cnt_q         <= 5'd0;
            first_err_q       <= 4'd0;
            first_err_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            vec_q             <= vec_d;
            hcnt_q            <= hcnt_d;
            abcd_q            <= abcd_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
            err_cnt_q         <= err_cnt_d;
            first_err_q       <= first_err_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    assign a               = abcd_q[3];
    assign b               = abcd_q[2];
    assign c               = abcd_q[1];
    assign d               = abcd_q[0];
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_cnt_q;
    assign first_err       = first_err_q;
    assign first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Purpose : directed bench for truth_table_sweeper with HOLD=2 and HOLD=1 instances.
// Latency : checks exact sweep latency (16*HOLD) and per-cycle vector stepping.
// Backpressure: n/a; start pulses are driven from the bench, including while busy.
module tb_truth_table_sweeper;

    logic clk;
    logic rst;
    logic start2;
    logic start1;
    logic [1:0] fault;   // 0: golden, 1: y stuck at 0, 2: z inverted
    logic sel;           // 0: observe HOLD=2 instance, 1: HOLD=1 instance

    logic a2, b2, c2, d2, y2, z2, busy2, done2, pass2, fev2;
    logic [4:0] ec2;
    logic [3:0] fe2;
    logic a1, b1, c1, d1, y1, z1, busy1, done1, pass1, fev1;
    logic [4:0] ec1;
    logic [3:0] fe1;

    int total;
    int pass_cnt;
    int fail_cnt;
    int lat;

    // Downstream block model: y = a&b&c&d, z = a|b|c|d, with optional faults.
    function automatic logic model_y(input logic [3:0] v, input logic [1:0] f);
        model_y = (f == 2'd1) ? 1'b0 : (&v);
    endfunction

    function automatic logic model_z(input logic [3:0] v, input logic [1:0] f);
        model_z = (f == 2'd2) ? ~(|v) : (|v);
    endfunction

    assign y2 = model_y({a2, b2, c2, d2}, fault);
    assign z2 = model_z({a2, b2, c2, d2}, fault);
    assign y1 = model_y({a1, b1, c1, d1}, fault);
    assign z1 = model_z({a1, b1, c1, d1}, fault);

    truth_table_sweeper #(.HOLD(2), .EXP_Y(16'h8000), .EXP_Z(16'hFFFE)) uut (
        .clk(clk), .rst(rst), .start(start2),
        .a(a2), .b(b2), .c(c2), .d(d2), .y(y2), .z(z2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(ec2), .first_err(fe2), .first_err_valid(fev2)
    );

    truth_table_sweeper #(.HOLD(1), .EXP_Y(16'h8000), .EXP_Z(16'hFFFE)) uut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(a1), .b(b1), .c(c1), .d(d1), .y(y1), .z(z1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(ec1), .first_err(fe1), .first_err_valid(fev1)
    );

    // Observation mux so the sweep task serves both instances.
    logic [3:0] o_abcd;
    logic       o_busy, o_done, o_pass, o_fev;
    logic [4:0] o_ec;
    logic [3:0] o_fe;
    assign o_abcd = sel ? {a1, b1, c1, d1} : {a2, b2, c2, d2};
    assign o_busy = sel ? busy1 : busy2;
    assign o_done = sel ? done1 : done2;
    assign o_pass = sel ? pass1 : pass2;
    assign o_fev  = sel ? fev1  : fev2;
    assign o_ec   = sel ? ec1   : ec2;
    assign o_fe   = sel ? fe1   : fe2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v;
        else     start2 = v;
    endtask

    // Pulse start, then walk negedges until done (bounded). cyc = edges since
    // the start edge at the moment done is seen. stop_at >= 0 leaves early.
    task automatic sweep(input int hold, input int poke_at, input int stop_at,
                         input bit trace, output int cyc);
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        cyc = 0;
        check("clr_err", 32'(o_ec), 0);
        check("clr_fev", 32'(o_fev), 0);
        check("clr_done", 32'(o_done), 0);
        check("clr_pass", 32'(o_pass), 0);
        while (!o_done && cyc < 200) begin
            if (trace) begin
                check("vec", 32'(o_abcd), 32'((cyc / hold) % 16));
                check("busy_run", 32'(o_busy), 1);
            end
            if (cyc == stop_at) break;
            set_start(cyc == poke_at);
            @(negedge clk);
            cyc++;
        end
        set_start(1'b0);
    endtask

    initial begin
        total    = 0;
        pass_cnt = 0;
        fail_cnt = 0;
        fault    = 2'd0;
        sel      = 1'b0;
        rst      = 1'b1;
        start2   = 1'b1;
        start1   = 1'b1;

        // Reset held two cycles with start high: reset wins.
        repeat (2) @(negedge clk);
        check("rst_abcd", 32'({a2, b2, c2, d2}), 0);
        check("rst_busy", 32'(busy2), 0);
        check("rst_done", 32'(done2), 0);
        check("rst_pass", 32'(pass2), 0);
        check("rst_err", 32'(ec2), 0);
        check("rst_fe", 32'(fe2), 0);
        check("rst_fev", 32'(fev2), 0);
        check("rst1_busy", 32'(busy1), 0);
        check("rst1_abcd", 32'({a1, b1, c1, d1}), 0);
        rst    = 1'b0;
        start2 = 1'b0;
        start1 = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy2), 0);

        // Golden sweep, HOLD=2, with per-cycle trace.
        sweep(2, -1, -1, 1'b1, lat);
        check("gold_lat", 32'(lat), 32);
        check("gold_err", 32'(o_ec), 0);
        check("gold_pass", 32'(o_pass), 1);
        check("gold_fev", 32'(o_fev), 0);
        check("gold_abcd", 32'(o_abcd), 32'hF);
        check("gold_busy", 32'(o_busy), 0);
        repeat (3) @(negedge clk);
        check("done_hold", 32'(o_done), 1);
        check("pass_hold", 32'(o_pass), 1);

        // y stuck at 0: only vector 15 fails.
        fault = 2'd1;
        sweep(2, -1, -1, 1'b0, lat);
        check("y0_lat", 32'(lat), 32);
        check("y0_err", 32'(o_ec), 1);
        check("y0_fe", 32'(o_fe), 15);
        check("y0_fev", 32'(o_fev), 1);
        check("y0_pass", 32'(o_pass), 0);

        // z inverted: every vector fails.
        fault = 2'd2;
        sweep(2, -1, -1, 1'b0, lat);
        check("zinv_err", 32'(o_ec), 16);
        check("zinv_fe", 32'(o_fe), 0);
        check("zinv_fev", 32'(o_fev), 1);
        check("zinv_pass", 32'(o_pass), 0);

        // Golden from DONE after a faulty run, start re-pulsed at vector 5.
        fault = 2'd0;
        sweep(2, 10, -1, 1'b1, lat);
        check("poke_lat", 32'(lat), 32);
        check("poke_err", 32'(o_ec), 0);
        check("poke_pass", 32'(o_pass), 1);

        // Reset during vector 7 of a faulty sweep (vectors 0..6 already failed).
        fault = 2'd2;
        sweep(2, -1, 14, 1'b0, lat);
        check("mid_vec", 32'(o_abcd), 7);
        check("mid_err", 32'(o_ec), 7);
        check("mid_fe", 32'(o_fe), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ab_abcd", 32'(o_abcd), 0);
        check("ab_busy", 32'(o_busy), 0);
        check("ab_done", 32'(o_done), 0);
        check("ab_err", 32'(o_ec), 0);
        check("ab_fev", 32'(o_fev), 0);
        @(negedge clk);
        check("ab_idle", 32'(o_busy), 0);
        fault = 2'd0;
        sweep(2, -1, -1, 1'b1, lat);
        check("re_lat", 32'(lat), 32);
        check("re_pass", 32'(o_pass), 1);

        // HOLD=1 instance: faulty run then golden from DONE.
        sel   = 1'b1;
        fault = 2'd1;
        sweep(1, -1, -1, 1'b0, lat);
        check("h1_y0_lat", 32'(lat), 16);
        check("h1_y0_err", 32'(o_ec), 1);
        check("h1_y0_fe", 32'(o_fe), 15);
        fault = 2'd0;
        sweep(1, -1, -1, 1'b1, lat);
        check("h1_lat", 32'(lat), 16);
        check("h1_err", 32'(o_ec), 0);
        check("h1_pass", 32'(o_pass), 1);
        check("h1_fev", 32'(o_fev), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
